// File: rtl/newton_row_sequencer.sv
// ---------------------------------------------------------------------------
// newton_row_sequencer
//
// Control FSM for the signed-digit V-value slice datapath of the Newton
// divider. Each row of a division is one ZERO phase, SLICES CARRY phases
// and one PROP phase. A division is ITERATIONS rows long. The block also
// produces the global slice counter, a one-step-delayed copy of it and the
// row index.
//
// Parameters
//   SLICES      carry-feedback cycles per row (1..63)
//   ITERATIONS  rows per division (1..127)
//
// Ports
//   clk                input   rising-edge clock
//   reset              input   synchronous, active-high reset
//   start              input   request a division (honoured only in IDLE)
//   hold               input   stall: freezes state and counters
//   abort              input   drop the current division, no done
//   STATE[1:0]         output  00 IDLE, 10 ZERO, 01 CARRY, 11 PROP
//   cnt_master[8:0]    output  slice counter, +1 per advance, wraps mod 512
//   cnt_master_dis[8:0]output  cnt_master value before its latest advance
//   computation_cycle  output  current row index 0..ITERATIONS-1
//   write_enable       output  datapath enable = busy & ~hold
//   busy               output  STATE != IDLE
//   done               output  one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
module newton_row_sequencer #(
  parameter int SLICES     = 4,
  parameter int ITERATIONS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hold,
  input  logic       abort,
  output logic [1:0] STATE,
  output logic [8:0] cnt_master,
  output logic [8:0] cnt_master_dis,
  output logic [6:0] computation_cycle,
  output logic       write_enable,
  output logic       busy,
  output logic       done
);

  // The phase codes are consumed directly by the slice datapath, so the
  // encoding is fixed rather than left to the synthesis tool.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ZERO  = 2'b10;
  localparam logic [1:0] ST_CARRY = 2'b01;
  localparam logic [1:0] ST_PROP  = 2'b11;

  localparam logic [5:0] LAST_SLICE = 6'(SLICES - 1);
  localparam logic [6:0] LAST_ROW   = 7'(ITERATIONS - 1);

  logic [5:0] slice_cnt;

  // Both decodes look only at registered state and hold, so start never
  // has a combinational path to an output.
  assign busy         = (STATE != ST_IDLE);
  assign write_enable = busy & ~hold;

  // Main sequencer. In IDLE only start/abort matter. While busy, abort wins
  // over hold, and hold freezes everything. Every other busy cycle is an
  // advance: the slice counters step and the phase moves on. done is a
  // default-low pulse raised only by the final PROP advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      STATE             <= ST_IDLE;
      cnt_master        <= '0;
      cnt_master_dis    <= '0;
      computation_cycle <= '0;
      slice_cnt         <= '0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      if (STATE == ST_IDLE) begin
        if (start && !abort) begin
          STATE             <= ST_ZERO;
          cnt_master        <= '0;
          cnt_master_dis    <= '0;
          computation_cycle <= '0;
          slice_cnt         <= '0;
        end
      end else if (abort) begin
        // Counters keep their values so the datapath can be inspected.
        STATE <= ST_IDLE;
      end else if (!hold) begin
        cnt_master_dis <= cnt_master;
        cnt_master     <= cnt_master + 9'd1;
        case (STATE)
          ST_ZERO: begin
            STATE     <= ST_CARRY;
            slice_cnt <= '0;
          end
          ST_CARRY: begin
            slice_cnt <= slice_cnt + 6'd1;
            if (slice_cnt == LAST_SLICE) begin
              STATE <= ST_PROP;
            end
          end
          default: begin
            // PROP: either finish the division or start the next row.
            // On the last row the row index is left at ITERATIONS-1.
            if (computation_cycle == LAST_ROW) begin
              STATE <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              computation_cycle <= computation_cycle + 7'd1;
              STATE             <= ST_ZERO;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_newton_row_sequencer.sv
// ---------------------------------------------------------------------------
// tb_newton_row_sequencer
//
// Drives three sequencer instances with shared inputs:
//   dut 0: SLICES=4,  ITERATIONS=3
//   dut 1: SLICES=63, ITERATIONS=9  (counter wrap)
//   dut 2: SLICES=1,  ITERATIONS=1  (smallest configuration)
// A reference model counts advances within a division and derives phase,
// row and counters from that count arithmetically. Every cycle all outputs
// of all instances are compared with the model; directed scenarios also pin
// hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_newton_row_sequencer;

  localparam int ND = 3;
  localparam int SL [ND] = '{4, 63, 1};
  localparam int IT [ND] = '{3, 9, 1};

  logic clk;
  logic reset;
  logic start;
  logic hold;
  logic abort;

  logic [1:0] stateO [ND];
  logic [8:0] cntO   [ND];
  logic [8:0] disO   [ND];
  logic [6:0] ccO    [ND];
  logic       weO    [ND];
  logic       busyO  [ND];
  logic       doneO  [ND];

  int total = 0;
  int bad   = 0;
  bit checkEn = 0;

  // Model state: busy flag, number of advances since the last start/reset,
  // and the registered done pulse.
  bit mBusy [ND];
  int mK    [ND];
  bit mDone [ND];

  newton_row_sequencer #(.SLICES(4), .ITERATIONS(3)) dut0 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .abort(abort),
    .STATE(stateO[0]), .cnt_master(cntO[0]), .cnt_master_dis(disO[0]),
    .computation_cycle(ccO[0]), .write_enable(weO[0]), .busy(busyO[0]),
    .done(doneO[0]));

  newton_row_sequencer #(.SLICES(63), .ITERATIONS(9)) dut1 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .abort(abort),
    .STATE(stateO[1]), .cnt_master(cntO[1]), .cnt_master_dis(disO[1]),
    .computation_cycle(ccO[1]), .write_enable(weO[1]), .busy(busyO[1]),
    .done(doneO[1]));

  newton_row_sequencer #(.SLICES(1), .ITERATIONS(1)) dut2 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .abort(abort),
    .STATE(stateO[2]), .cnt_master(cntO[2]), .cnt_master_dis(disO[2]),
    .computation_cycle(ccO[2]), .write_enable(weO[2]), .busy(busyO[2]),
    .done(doneO[2]));

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs derived from the advance count k of the division.
  function automatic logic [1:0] expState(int d);
    int pos;
    if (!mBusy[d]) return 2'b00;
    pos = mK[d] % (SL[d] + 2);
    if (pos == 0) return 2'b10;
    if (pos == SL[d] + 1) return 2'b11;
    return 2'b01;
  endfunction

  function automatic int expRow(int d);
    int r;
    r = mK[d] / (SL[d] + 2);
    if (r > IT[d] - 1) r = IT[d] - 1;
    return r;
  endfunction

  function automatic int expCnt(int d);
    return mK[d] % 512;
  endfunction

  function automatic int expDis(int d);
    return (mK[d] == 0) ? 0 : (mK[d] - 1) % 512;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 unit after the rising edge and are sampled on the next.
  task automatic applyStimulus(input logic r, input logic s, input logic h, input logic a);
    @(posedge clk);
    #1;
    reset = r;
    start = s;
    hold  = h;
    abort = a;
  endtask

  // Reference model, stepped on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (reset) begin
        mBusy[d] = 0;
        mK[d]    = 0;
        mDone[d] = 0;
      end else if (!mBusy[d]) begin
        mDone[d] = 0;
        if (start && !abort) begin
          mBusy[d] = 1;
          mK[d]    = 0;
        end
      end else if (abort) begin
        mBusy[d] = 0;
      end else if (!hold) begin
        mK[d] = mK[d] + 1;
        if (mK[d] == IT[d] * (SL[d] + 2)) begin
          mBusy[d] = 0;
          mDone[d] = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int d = 0; d < ND; d++) begin
        checkOutput($sformatf("d%0d.STATE", d), int'(stateO[d]), int'(expState(d)));
        checkOutput($sformatf("d%0d.cnt_master", d), int'(cntO[d]), expCnt(d));
        checkOutput($sformatf("d%0d.cnt_master_dis", d), int'(disO[d]), expDis(d));
        checkOutput($sformatf("d%0d.computation_cycle", d), int'(ccO[d]), expRow(d));
        checkOutput($sformatf("d%0d.busy", d), int'(busyO[d]), int'(mBusy[d]));
        checkOutput($sformatf("d%0d.write_enable", d), int'(weO[d]), int'(mBusy[d] & ~hold));
        checkOutput($sformatf("d%0d.done", d), int'(doneO[d]), int'(mDone[d]));
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    checkEn = 1;

    // Scenario 1: plain division on dut0.
    $display("[TB] scenario 1: basic sequence");
    applyStimulus(1, 0, 0, 0);
    for (int c = 0; c <= 20; c++) begin
      applyStimulus(0, c == 0, 0, 0);
      #2;
      case (c)
        0: begin
          checkOutput("s1.reset.STATE", int'(stateO[0]), 0);
          checkOutput("s1.reset.cnt", int'(cntO[0]), 0);
          checkOutput("s1.reset.we", int'(weO[0]), 0);
        end
        1: begin
          checkOutput("s1.c1.STATE", int'(stateO[0]), 2);
          checkOutput("s1.c1.cnt", int'(cntO[0]), 0);
        end
        2: checkOutput("s1.c2.STATE", int'(stateO[0]), 1);
        6: begin
          checkOutput("s1.c6.STATE", int'(stateO[0]), 3);
          checkOutput("s1.c6.cnt", int'(cntO[0]), 5);
          checkOutput("s1.c6.cc", int'(ccO[0]), 0);
        end
        7: begin
          checkOutput("s1.c7.STATE", int'(stateO[0]), 2);
          checkOutput("s1.c7.cc", int'(ccO[0]), 1);
          checkOutput("s1.c7.cnt", int'(cntO[0]), 6);
        end
        18: begin
          checkOutput("s1.c18.STATE", int'(stateO[0]), 3);
          checkOutput("s1.c18.cnt", int'(cntO[0]), 17);
        end
        19: begin
          checkOutput("s1.c19.STATE", int'(stateO[0]), 0);
          checkOutput("s1.c19.done", int'(doneO[0]), 1);
          checkOutput("s1.c19.cnt", int'(cntO[0]), 18);
          checkOutput("s1.c19.dis", int'(disO[0]), 17);
          checkOutput("s1.c19.cc", int'(ccO[0]), 2);
        end
        20: checkOutput("s1.c20.done", int'(doneO[0]), 0);
        default: ;
      endcase
    end

    // Scenario 2: hold during cycles 3 and 4.
    $display("[TB] scenario 2: hold");
    applyStimulus(1, 0, 0, 0);
    for (int c = 0; c <= 22; c++) begin
      applyStimulus(0, c == 0, (c == 3) || (c == 4), 0);
      #2;
      case (c)
        3: begin
          checkOutput("s2.c3.STATE", int'(stateO[0]), 1);
          checkOutput("s2.c3.cnt", int'(cntO[0]), 2);
          checkOutput("s2.c3.we", int'(weO[0]), 0);
        end
        4: begin
          checkOutput("s2.c4.cnt", int'(cntO[0]), 2);
          checkOutput("s2.c4.we", int'(weO[0]), 0);
        end
        5: checkOutput("s2.c5.cnt", int'(cntO[0]), 2);
        20: checkOutput("s2.c20.STATE", int'(stateO[0]), 3);
        21: checkOutput("s2.c21.done", int'(doneO[0]), 1);
        default: ;
      endcase
    end

    // Scenario 3: abort mid-division, then restart.
    $display("[TB] scenario 3: abort");
    applyStimulus(1, 0, 0, 0);
    for (int c = 0; c <= 28; c++) begin
      applyStimulus(0, (c == 0) || (c == 26), 0, c == 10);
      #2;
      case (c)
        11: begin
          checkOutput("s3.c11.STATE", int'(stateO[0]), 0);
          checkOutput("s3.c11.busy", int'(busyO[0]), 0);
          checkOutput("s3.c11.done", int'(doneO[0]), 0);
          checkOutput("s3.c11.cnt", int'(cntO[0]), 9);
          checkOutput("s3.c11.cc", int'(ccO[0]), 1);
        end
        25: checkOutput("s3.c25.done", int'(doneO[0]), 0);
        27: begin
          checkOutput("s3.c27.STATE", int'(stateO[0]), 2);
          checkOutput("s3.c27.cnt", int'(cntO[0]), 0);
          checkOutput("s3.c27.cc", int'(ccO[0]), 0);
        end
        default: ;
      endcase
    end

    // Scenario 4: start while busy ignored; reset mid-division; restart.
    $display("[TB] scenario 4: reset mid-division");
    applyStimulus(1, 0, 0, 0);
    for (int c = 0; c <= 16; c++) begin
      applyStimulus(c == 12, (c == 0) || (c == 5) || (c == 13), 0, 0);
      #2;
      case (c)
        6: begin
          checkOutput("s4.c6.STATE", int'(stateO[0]), 3);
          checkOutput("s4.c6.cnt", int'(cntO[0]), 5);
        end
        13: begin
          checkOutput("s4.c13.STATE", int'(stateO[0]), 0);
          checkOutput("s4.c13.cnt", int'(cntO[0]), 0);
          checkOutput("s4.c13.dis", int'(disO[0]), 0);
          checkOutput("s4.c13.cc", int'(ccO[0]), 0);
          checkOutput("s4.c13.done", int'(doneO[0]), 0);
          checkOutput("s4.c13.busy", int'(busyO[0]), 0);
        end
        14: checkOutput("s4.c14.STATE", int'(stateO[0]), 2);
        default: ;
      endcase
    end

    // Scenario 5: long division on dut1, counter wraps past 511.
    $display("[TB] scenario 5: counter wrap");
    applyStimulus(1, 0, 0, 0);
    for (int c = 0; c <= 600; c++) begin
      applyStimulus(0, c == 0, 0, 0);
      #2;
      case (c)
        512: checkOutput("s5.c512.cnt", int'(cntO[1]), 511);
        513: begin
          checkOutput("s5.c513.cnt", int'(cntO[1]), 0);
          checkOutput("s5.c513.dis", int'(disO[1]), 511);
        end
        585: checkOutput("s5.c585.STATE", int'(stateO[1]), 3);
        586: begin
          checkOutput("s5.c586.done", int'(doneO[1]), 1);
          checkOutput("s5.c586.cc", int'(ccO[1]), 8);
          checkOutput("s5.c586.cnt", int'(cntO[1]), 73);
        end
        default: ;
      endcase
    end

    // Scenario 6: start+abort in IDLE, then a minimal division on dut2.
    $display("[TB] scenario 6: corner configuration");
    applyStimulus(1, 0, 0, 0);
    for (int c = 0; c <= 7; c++) begin
      applyStimulus(0, (c == 0) || (c == 1), 0, c == 0);
      #2;
      case (c)
        1: begin
          checkOutput("s6.c1.STATE", int'(stateO[2]), 0);
          checkOutput("s6.c1.busy", int'(busyO[2]), 0);
        end
        2: checkOutput("s6.c2.STATE", int'(stateO[2]), 2);
        3: checkOutput("s6.c3.STATE", int'(stateO[2]), 1);
        4: checkOutput("s6.c4.STATE", int'(stateO[2]), 3);
        5: begin
          checkOutput("s6.c5.STATE", int'(stateO[2]), 0);
          checkOutput("s6.c5.done", int'(doneO[2]), 1);
          checkOutput("s6.c5.cnt", int'(cntO[2]), 3);
        end
        6: checkOutput("s6.c6.done", int'(doneO[2]), 0);
        default: ;
      endcase
    end

    @(negedge clk);
    checkEn = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
